// File: rtl/lcd_hd44780_bus.sv
// HD44780 4-bit write-only bus driver. It runs the power-up init sequence itself,
// then sends one byte per accepted write as two nibbles followed by an execution wait.
module lcd_hd44780_bus #(
    parameter int unsigned EN_HIGH_CYC    = 12,
    parameter int unsigned NIBBLE_GAP_CYC = 27,
    parameter int unsigned CMD_WAIT_CYC   = 1100,
    parameter int unsigned CLEAR_WAIT_CYC = 44000,
    parameter int unsigned POWERUP_CYC    = 405000,
    parameter int unsigned INIT_WAIT_CYC  = 111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    input  logic       cmd_data_select,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [3:0] lcd_data
);

    // A zero-length parameter still occupies one cycle.
    localparam int unsigned EN_LEN    = (EN_HIGH_CYC    == 0) ? 1 : EN_HIGH_CYC;
    localparam int unsigned GAP_LEN   = (NIBBLE_GAP_CYC == 0) ? 1 : NIBBLE_GAP_CYC;
    localparam int unsigned CMD_LEN   = (CMD_WAIT_CYC   == 0) ? 1 : CMD_WAIT_CYC;
    localparam int unsigned CLEAR_LEN = (CLEAR_WAIT_CYC == 0) ? 1 : CLEAR_WAIT_CYC;
    localparam int unsigned PWR_LEN   = (POWERUP_CYC    == 0) ? 1 : POWERUP_CYC;
    localparam int unsigned INIT_LEN  = (INIT_WAIT_CYC  == 0) ? 1 : INIT_WAIT_CYC;

    localparam int unsigned MAX_A   = (EN_LEN > GAP_LEN) ? EN_LEN : GAP_LEN;
    localparam int unsigned MAX_B   = (CMD_LEN > CLEAR_LEN) ? CMD_LEN : CLEAR_LEN;
    localparam int unsigned MAX_C   = (PWR_LEN > INIT_LEN) ? PWR_LEN : INIT_LEN;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_LEN = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] EN_LAST    = CW'(EN_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_LEN - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_LEN - 1);
    localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_LEN - 1);
    localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_LEN - 1);

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_PULSE   = 3'd3,
        S_GAP     = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    // Steps 0-2 are the 0x3 nibbles, step 3 the 0x2 nibble, steps 4-7 full command bytes.
    function automatic logic [7:0] init_byte(input logic [2:0] step);
        logic [7:0] b;
        case (step)
            3'd0, 3'd1, 3'd2: b = 8'h03;
            3'd3:             b = 8'h02;
            3'd4:             b = 8'h28;
            3'd5:             b = 8'h0C;
            3'd6:             b = 8'h06;
            3'd7:             b = 8'h01;
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_clear_cmd(input logic [7:0] b);
        return (b == 8'h01) || (b == 8'h02) || (b == 8'h03);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic          in_init_q, in_init_d;
    logic          single_q, single_d;
    logic          nib_hi_q, nib_hi_d;
    logic [7:0]    byte_q, byte_d;
    logic          busy_q, busy_d;
    logic          init_done_q, init_done_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_en_q, lcd_en_d;
    logic [3:0]    lcd_data_q, lcd_data_d;

    logic [CW-1:0] cnt_inc_s;
    logic [CW-1:0] wait_last_s;
    logic [2:0]    start_step_s;
    logic [7:0]    start_byte_s;
    logic          start_single_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        in_init_d   = in_init_q;
        single_d    = single_q;
        nib_hi_d    = nib_hi_q;
        byte_d      = byte_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        lcd_en_d    = 1'b0;
        cnt_inc_s   = cnt_q + CW'(1);

        if (single_q) begin
            if (step_q < 3'd3) begin
                wait_last_s = INIT_LAST;
            end else begin
                wait_last_s = CMD_LAST;
            end
        end else if (!lcd_rs_q && is_clear_cmd(byte_q)) begin
            wait_last_s = CLEAR_LAST;
        end else begin
            wait_last_s = CMD_LAST;
        end

        if (state_q == S_POWERUP) begin
            start_step_s = 3'd0;
        end else begin
            start_step_s = step_q + 3'd1;
        end
        start_byte_s   = init_byte(start_step_s);
        start_single_s = (start_step_s < 3'd4);

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d  = S_SETUP;
                    cnt_d    = '0;
                    step_d   = start_step_s;
                    byte_d   = start_byte_s;
                    single_d = start_single_s;
                    nib_hi_d = !start_single_s;
                    lcd_rs_d = 1'b0;
                    if (start_single_s) begin
                        lcd_data_d = start_byte_s[3:0];
                    end else begin
                        lcd_data_d = start_byte_s[7:4];
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_IDLE: begin
                if (write_enable && !busy_q) begin
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    byte_d     = data_in;
                    single_d   = 1'b0;
                    nib_hi_d   = 1'b1;
                    busy_d     = 1'b1;
                    lcd_rs_d   = cmd_data_select;
                    lcd_data_d = data_in[7:4];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d  = S_PULSE;
                cnt_d    = '0;
                lcd_en_d = 1'b1;
            end
            S_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d = '0;
                    if (single_q || !nib_hi_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d    = cnt_inc_s;
                    lcd_en_d = 1'b1;
                end
            end
            S_GAP: begin
                // Low nibble is driven on its own setup cycle, so the high nibble holds through the gap.
                if (cnt_q == GAP_LAST) begin
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    nib_hi_d   = 1'b0;
                    lcd_data_d = byte_q[3:0];
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last_s) begin
                    cnt_d = '0;
                    if (in_init_q && (step_q != 3'd7)) begin
                        state_d  = S_SETUP;
                        step_d   = start_step_s;
                        byte_d   = start_byte_s;
                        single_d = start_single_s;
                        nib_hi_d = !start_single_s;
                        if (start_single_s) begin
                            lcd_data_d = start_byte_s[3:0];
                        end else begin
                            lcd_data_d = start_byte_s[7:4];
                        end
                    end else begin
                        state_d     = S_IDLE;
                        in_init_d   = 1'b0;
                        busy_d      = 1'b0;
                        init_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and restarts init.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_POWERUP;
            cnt_q       <= '0;
            step_q      <= 3'd0;
            in_init_q   <= 1'b1;
            single_q    <= 1'b0;
            nib_hi_q    <= 1'b0;
            byte_q      <= 8'h00;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_data_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            in_init_q   <= in_init_d;
            single_q    <= single_d;
            nib_hi_q    <= nib_hi_d;
            byte_q      <= byte_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
            lcd_data_q  <= lcd_data_d;
        end
    end

    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_hd44780_bus.sv
// Randomised bench for lcd_hd44780_bus: a bus monitor collects nibbles and pulse timing,
// and expected nibble lists and busy lengths come from the timing rules of the bus.
module tb_lcd_hd44780_bus;

    localparam int EN_H   = 2;
    localparam int GAP    = 3;
    localparam int CMD_W  = 5;
    localparam int CLR_W  = 20;
    localparam int PWR    = 10;
    localparam int INIT_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       write_enable = 1'b0;
    logic       cmd_data_select = 1'b0;
    logic       busy, init_done, lcd_rs, lcd_rw, lcd_en;
    logic [3:0] lcd_data;

    int checks = 0;
    int errors = 0;
    logic [4:0] mon_q[$];

    lcd_hd44780_bus #(
        .EN_HIGH_CYC(EN_H), .NIBBLE_GAP_CYC(GAP), .CMD_WAIT_CYC(CMD_W),
        .CLEAR_WAIT_CYC(CLR_W), .POWERUP_CYC(PWR), .INIT_WAIT_CYC(INIT_W)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .write_enable(write_enable),
        .cmd_data_select(cmd_data_select), .busy(busy), .init_done(init_done),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int byte_cycles(input logic [7:0] b, input logic rs);
        int w;
        if (!rs && b >= 8'd1 && b <= 8'd3) w = CLR_W;
        else w = CMD_W;
        return 2 + 2 * EN_H + GAP + w;
    endfunction

    // Bus monitor: records {rs,data} per enable pulse and checks pulse width and data stability.
    initial begin : monitor
        bit in_pulse;
        int width;
        logic [4:0] cur, prev;
        in_pulse = 1'b0;
        width = 0;
        cur = 5'd0;
        prev = 5'd0;
        forever begin
            @(negedge clk);
            check("rw_low", lcd_rw, 1'b0);
            if (rst) begin
                in_pulse = 1'b0;
                width = 0;
            end else if (lcd_en) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    width = 0;
                    cur = {lcd_rs, lcd_data};
                    mon_q.push_back(cur);
                    check("setup_before_en", prev, cur);
                end
                width++;
                check("en_data_stable", {lcd_rs, lcd_data}, cur);
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                check("en_width", width, EN_H);
                check("hold_after_en", {lcd_rs, lcd_data}, cur);
            end
            prev = {lcd_rs, lcd_data};
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic compare_nibbles(input string tag, input logic [4:0] exp[$]);
        check({tag, "_count"}, mon_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < mon_q.size(); i++) begin
            check({tag, "_nibble"}, mon_q[i], exp[i]);
        end
    endtask

    task automatic run_init(input bit poke);
        logic [4:0] exp[$];
        logic [7:0] ib[4];
        int n, exp_busy;
        ib = '{8'h28, 8'h0C, 8'h06, 8'h01};
        exp = {};
        repeat (3) exp.push_back({1'b0, 4'h3});
        exp.push_back({1'b0, 4'h2});
        exp_busy = PWR + 3 * (1 + EN_H + INIT_W) + (1 + EN_H + CMD_W);
        for (int i = 0; i < 4; i++) begin
            exp.push_back({1'b0, ib[i][7:4]});
            exp.push_back({1'b0, ib[i][3:0]});
            exp_busy += byte_cycles(ib[i], 1'b0);
        end
        @(negedge clk);
        mon_q.delete();
        rst = 1'b0;
        check("rel_busy", busy, 1'b1);
        check("rel_init_done", init_done, 1'b0);
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) break;
            check("init_done_early", init_done, 1'b0);
            write_enable = poke && (n < 100) && ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
        end
        write_enable = 1'b0;
        check("init_busy_cycles", n, exp_busy);
        check("init_done_set", init_done, 1'b1);
        check("init_busy_low", busy, 1'b0);
        compare_nibbles("init", exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs);
        logic [4:0] exp[$];
        int n;
        @(negedge clk);
        mon_q.delete();
        data_in = b;
        cmd_data_select = rs;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        data_in = 8'($urandom);
        cmd_data_select = !rs;
        check("accept_busy", busy, 1'b1);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) break;
        end
        check("byte_busy_cycles", n, byte_cycles(b, rs));
        check("init_done_hold", init_done, 1'b1);
        exp = {};
        exp.push_back({rs, b[7:4]});
        exp.push_back({rs, b[3:0]});
        compare_nibbles("byte", exp);
    endtask

    task automatic held_write();
        logic [7:0] acc_b[2];
        logic       acc_rs[2];
        int         acc_cyc[2];
        logic [4:0] exp[$];
        int acc, cyc, n;
        acc_b = '{8'h00, 8'h00};
        acc_rs = '{1'b0, 1'b0};
        acc_cyc = '{0, 0};
        @(negedge clk);
        mon_q.delete();
        write_enable = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 2 && cyc < 500) begin
            data_in = 8'($urandom);
            cmd_data_select = 1'($urandom_range(0, 1));
            if (!busy) begin
                acc_b[acc] = data_in;
                acc_rs[acc] = cmd_data_select;
                acc_cyc[acc] = cyc;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        write_enable = 1'b0;
        check("held_accepts", acc, 2);
        check("held_reaccept_gap", acc_cyc[1] - acc_cyc[0], byte_cycles(acc_b[0], acc_rs[0]) + 1);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        exp = {};
        for (int i = 0; i < 2; i++) begin
            exp.push_back({acc_rs[i], acc_b[i][7:4]});
            exp.push_back({acc_rs[i], acc_b[i][3:0]});
        end
        compare_nibbles("held", exp);
    endtask

    task automatic reset_mid_byte();
        int n;
        @(negedge clk);
        mon_q.delete();
        data_in = 8'h5A;
        cmd_data_select = 1'b1;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        n = 0;
        while (mon_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("low_nibble_seen", mon_q.size(), 2);
        check("en_high_before_rst", lcd_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_en", lcd_en, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_init_done", init_done, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_data", lcd_data, 4'h0);
        check("rst_rw", lcd_rw, 1'b0);
        repeat (3) @(posedge clk);
        run_init(1'b1);
    endtask

    initial begin : main
        logic [7:0] b;
        logic r;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b1);
        check("reset_init_done", init_done, 1'b0);
        check("reset_en", lcd_en, 1'b0);
        check("reset_rs", lcd_rs, 1'b0);
        check("reset_data", lcd_data, 4'h0);

        run_init(1'b0);
        send_byte(8'h41, 1'b1);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(1, 3));
                r = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_byte(b, r);
        end
        held_write();
        reset_mid_byte();
        send_byte(8'hC3, 1'b1);
        send_byte(8'h03, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_bus.md
LCD_HD44780_BUS -- requirements
Module: lcd_hd44780_bus

Interface
REQ-001 Parameter EN_HIGH_CYC, 12: cycles lcd_en held high per nibble.
REQ-002 Parameter NIBBLE_GAP_CYC, 27: cycles lcd_en low between high and low nibble of one byte.
REQ-003 Parameter CMD_WAIT_CYC, 1100: post-byte execution wait for normal commands and data.
REQ-004 Parameter CLEAR_WAIT_CYC, 44000: post-byte wait for commands 0x01, 0x02 and 0x03.
REQ-005 Parameter POWERUP_CYC, 405000: idle wait after reset before the first init nibble.
REQ-006 Parameter INIT_WAIT_CYC, 111000: wait after each 0x3 init nibble.
REQ-007 Port clk, input, 1: single clock for all logic.
REQ-008 Port rst, input, 1: reset, asynchronous, active-high.
REQ-009 Port data_in, input, 8: byte to send.
REQ-010 Port write_enable, input, 1: byte-write request, sampled each clk edge.
REQ-011 Port cmd_data_select, input, 1: 0 = command (RS=0), 1 = data (RS=1).
REQ-012 Port busy, output, 1: 1 while initialising or processing a byte.
REQ-013 Port init_done, output, 1: 1 once the init sequence has completed.
REQ-014 Ports lcd_rs, lcd_rw, lcd_en, output, 1 each: HD44780 control pins.
REQ-015 Port lcd_data, output, 4: HD44780 DB7..DB4.
REQ-016 All outputs SHALL be registered; no combinational path from inputs to outputs.

Function
REQ-017 lcd_rw SHALL be constant 0 (write-only bus, busy flag never read).
REQ-018 Nibble transfer: 1 setup cycle (lcd_data/lcd_rs valid, lcd_en=0), then EN_HIGH_CYC cycles with lcd_en=1; lcd_data and lcd_rs SHALL be stable from setup until 1 cycle after lcd_en falls.
REQ-019 Byte transfer sequence:
- high nibble (data_in[7:4]);
- NIBBLE_GAP_CYC cycles with lcd_en=0;
- low nibble (data_in[3:0]);
- wait, CLEAR_WAIT_CYC if RS=0 and byte is 0x01–0x03, else CMD_WAIT_CYC.
REQ-020 Byte occupancy SHALL be exactly 2+2*EN_HIGH_CYC+NIBBLE_GAP_CYC+wait cycles.
REQ-021 A write is accepted on a clk edge where write_enable=1 and busy=0.
- data_in and cmd_data_select are latched at that edge.
- busy=1 from the next cycle through the last wait cycle.
- busy=0 the cycle after the wait ends.
REQ-022 write_enable while busy=1 (including during init) SHALL be ignored and not queued; holding write_enable high through busy falling SHALL start a new transfer on the first busy=0 edge.
REQ-023 States:
- POWERUP -> INIT_NIB (x3 nibble 0x3, each followed by INIT_WAIT) -> nibble 0x2 + CMD_WAIT;
- then INIT_BYTES: 0x28, 0x0C, 0x06, 0x01 as full command bytes per REQ-019;
- then IDLE, with SETUP/PULSE/GAP/WAIT sub-states shared by init and user bytes.
REQ-024 On completion of the init clear wait: init_done=1 and busy=0 in the same cycle; init_done SHALL then stay 1 until reset.
REQ-025 Internal wait counters SHALL be sized for the largest parameter value; a parameter of 0 SHALL behave as 1 cycle.
REQ-026 Between transfers and during waits: lcd_en=0; lcd_data and lcd_rs hold last driven values.

Reset
REQ-027 While rst=1, outputs SHALL be: busy=1, init_done=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0; state=POWERUP, counters=0.
REQ-028 rst asserted mid-transfer or mid-init SHALL abort immediately (asynchronously force lcd_en=0); the full init sequence restarts after rst falls.
REQ-029 The first cycle after rst falls SHALL be POWERUP cycle 1.

Verification
Bench parameters: EN_HIGH=2, GAP=3, CMD_WAIT=5, CLEAR_WAIT=20, POWERUP=10, INIT_WAIT=8.
REQ-030 Release rst -> busy=1 for exactly 122 cycles.
- nibbles on lcd_data in order: 3,3,3,2,2,8,0,C,0,6,0,1;
- each nibble has one lcd_en pulse of 2 cycles;
- lcd_rs=0 throughout;
- init_done=1 and busy=0 at cycle 123.
REQ-031 After init, write 0x41 with cmd_data_select=1 -> lcd_rs=1, nibbles 4 then 1, busy high exactly 14 cycles.
REQ-032 Write command 0x01 -> nibbles 0 then 1, lcd_rs=0, busy high exactly 29 cycles.
REQ-033 Hold write_enable=1 with data changing each cycle across two transfers -> exactly two bytes are sent, equal to the data_in values present on the two accepting edges; no write is accepted during busy.
REQ-034 Assert rst during lcd_en=1 of a data byte's low nibble -> lcd_en=0 immediately; all outputs at reset values; after release the REQ-030 init sequence repeats exactly.
REQ-035 Pulse write_enable during init -> ignored: the nibble sequence is unchanged and no extra lcd_en pulses occur.
